// File: rtl/of_pkg.sv
// of_pkg: shared constants and the decoded-instruction record passed from
// decode through operand fetch to execute.
package of_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned REG_ADDR_W = 3;
   localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
   localparam int unsigned PEND_W     = 2;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     imm;
      logic                  use_imm;
      logic                  reg_write;
   } of_instr_t;

endpackage

// File: rtl/of_scoreboard.sv
// of_scoreboard: per-register count of in-flight writes, RAW/overflow hazard
// detection for the instruction offered by decode, and a sticky underflow flag.
// Ports:
//   clock, resetN              clock, synchronous active-low reset
//   chk_rs/rt/rd, chk_use_imm,
//   chk_reg_write              fields of the instruction being checked
//   inc_en, inc_addr           an accepted instruction will write inc_addr
//   dec_en, dec_addr           writeback commits dec_addr
//   hazard                     offered instruction must stall
//   sb_error                   sticky: commit seen for a register with no pending write
module of_scoreboard
   import of_pkg::*;
(
   input  logic                  clock,
   input  logic                  resetN,
   input  logic [REG_ADDR_W-1:0] chk_rs,
   input  logic [REG_ADDR_W-1:0] chk_rt,
   input  logic [REG_ADDR_W-1:0] chk_rd,
   input  logic                  chk_use_imm,
   input  logic                  chk_reg_write,
   input  logic                  inc_en,
   input  logic [REG_ADDR_W-1:0] inc_addr,
   input  logic                  dec_en,
   input  logic [REG_ADDR_W-1:0] dec_addr,
   output logic                  hazard,
   output logic                  sb_error
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [PEND_W-1:0]   cnt_q [NUM_REGS];
   logic [PEND_W-1:0]   cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] inc_hit;
   logic [NUM_REGS-1:0] dec_hit;
   logic                sb_error_q;
   logic                sb_error_d;

   // Registered counts only: a commit in the same cycle does not release a stall.
   always_comb begin
      hazard = (cnt_q[chk_rs] != '0)
            || (!chk_use_imm && (cnt_q[chk_rt] != '0))
            || (chk_reg_write && (cnt_q[chk_rd] == CNT_MAX));
   end

   always_comb begin
      inc_hit    = inc_en ? (NUM_REGS'(1) << inc_addr) : '0;
      dec_hit    = dec_en ? (NUM_REGS'(1) << dec_addr) : '0;
      sb_error_d = sb_error_q;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (dec_hit[r] && (cnt_q[r] == '0)) begin
            sb_error_d = 1'b1;
         end
         // Simultaneous increment and decrement cancel; an unmatched
         // decrement of a zero count is clamped at zero.
         if (inc_hit[r] && !dec_hit[r]) begin
            cnt_d[r] = cnt_q[r] + 1'b1;
         end else if (!inc_hit[r] && dec_hit[r] && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         sb_error_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         sb_error_q <= sb_error_d;
      end
   end

   assign sb_error = sb_error_q;

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: accepts decoded instructions, drives register-file read
// addresses, captures the 1-cycle-latency read data and presents operands to
// execute over valid/ready. RAW hazards stall in decode via the scoreboard.
// Ports:
//   clock, resetN                   clock, synchronous active-low reset
//   dec*                            decode handshake and instruction fields
//   rfReadAddr1/2, rfReadData1/2    register file read ports (data 1 cycle later)
//   wbEn, wbAddr                    writeback commit
//   ex*                             execute handshake and operands
//   sbError                         sticky scoreboard underflow
module operand_fetch
   import of_pkg::*;
(
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  decValid,
   output logic                  decReady,
   input  logic [REG_ADDR_W-1:0] decRs,
   input  logic [REG_ADDR_W-1:0] decRt,
   input  logic [REG_ADDR_W-1:0] decRd,
   input  logic [DATA_W-1:0]     decImm,
   input  logic                  decUseImm,
   input  logic                  decRegWrite,
   output logic [REG_ADDR_W-1:0] rfReadAddr1,
   output logic [REG_ADDR_W-1:0] rfReadAddr2,
   input  logic [DATA_W-1:0]     rfReadData1,
   input  logic [DATA_W-1:0]     rfReadData2,
   input  logic                  wbEn,
   input  logic [REG_ADDR_W-1:0] wbAddr,
   output logic                  exValid,
   input  logic                  exReady,
   output logic [DATA_W-1:0]     exOpA,
   output logic [DATA_W-1:0]     exOpB,
   output logic [REG_ADDR_W-1:0] exRd,
   output logic                  exRegWrite,
   output logic                  sbError
);

   of_instr_t             dec_instr;
   of_instr_t             a_q, a_d;
   logic                  a_valid_q, a_valid_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_W-1:0]     ex_opa_q, ex_opa_d;
   logic [DATA_W-1:0]     ex_opb_q, ex_opb_d;
   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
   logic                  ex_rw_q, ex_rw_d;
   logic                  hazard;
   logic                  a_move;
   logic                  dec_ready;
   logic                  accept;

   of_scoreboard u_scoreboard (
      .clock         (clock),
      .resetN        (resetN),
      .chk_rs        (decRs),
      .chk_rt        (decRt),
      .chk_rd        (decRd),
      .chk_use_imm   (decUseImm),
      .chk_reg_write (decRegWrite),
      .inc_en        (accept && decRegWrite),
      .inc_addr      (decRd),
      .dec_en        (wbEn),
      .dec_addr      (wbAddr),
      .hazard        (hazard),
      .sb_error      (sbError)
   );

   always_comb begin
      dec_instr = '{rs: decRs, rt: decRt, rd: decRd, imm: decImm,
                    use_imm: decUseImm, reg_write: decRegWrite};

      a_move    = a_valid_q && (!out_valid_q || exReady);
      dec_ready = !hazard && (!a_valid_q || a_move);
      accept    = decValid && dec_ready;

      // A held stage A keeps re-reading its own sources, so the read data
      // seen next cycle always belongs to whatever occupies stage A.
      rfReadAddr1 = accept ? decRs : a_q.rs;
      rfReadAddr2 = accept ? decRt : a_q.rt;

      a_d         = a_q;
      a_valid_d   = a_valid_q;
      out_valid_d = out_valid_q;
      ex_opa_d    = ex_opa_q;
      ex_opb_d    = ex_opb_q;
      ex_rd_d     = ex_rd_q;
      ex_rw_d     = ex_rw_q;

      if (a_move) begin
         out_valid_d = 1'b1;
         ex_opa_d    = rfReadData1;
         ex_opb_d    = a_q.use_imm ? a_q.imm : rfReadData2;
         ex_rd_d     = a_q.rd;
         ex_rw_d     = a_q.reg_write;
      end else if (exReady) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         a_valid_d = 1'b1;
         a_d       = dec_instr;
      end else if (a_move) begin
         a_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         a_q         <= '0;
         a_valid_q   <= 1'b0;
         out_valid_q <= 1'b0;
         ex_opa_q    <= '0;
         ex_opb_q    <= '0;
         ex_rd_q     <= '0;
         ex_rw_q     <= 1'b0;
      end else begin
         a_q         <= a_d;
         a_valid_q   <= a_valid_d;
         out_valid_q <= out_valid_d;
         ex_opa_q    <= ex_opa_d;
         ex_opb_q    <= ex_opb_d;
         ex_rd_q     <= ex_rd_d;
         ex_rw_q     <= ex_rw_d;
      end
   end

   assign decReady   = dec_ready;
   assign exValid    = out_valid_q;
   assign exOpA      = ex_opa_q;
   assign exOpB      = ex_opb_q;
   assign exRd       = ex_rd_q;
   assign exRegWrite = ex_rw_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
   import of_pkg::*;

   logic       clock = 1'b0;
   logic       resetN;
   logic       decValid, decReady;
   logic [2:0] decRs, decRt, decRd;
   logic [7:0] decImm;
   logic       decUseImm, decRegWrite;
   logic [2:0] rfReadAddr1, rfReadAddr2;
   logic [7:0] rfReadData1, rfReadData2;
   logic       wbEn;
   logic [2:0] wbAddr;
   logic       exValid, exReady;
   logic [7:0] exOpA, exOpB;
   logic [2:0] exRd;
   logic       exRegWrite;
   logic       sbError;

   logic [7:0] rf [8];
   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;

   always #5 clock = ~clock;

   // Register file model: one-cycle read latency.
   always @(posedge clock) begin
      rfReadData1 <= rf[rfReadAddr1];
      rfReadData2 <= rf[rfReadAddr2];
   end

   operand_fetch dut (
      .clock       (clock),
      .resetN      (resetN),
      .decValid    (decValid),
      .decReady    (decReady),
      .decRs       (decRs),
      .decRt       (decRt),
      .decRd       (decRd),
      .decImm      (decImm),
      .decUseImm   (decUseImm),
      .decRegWrite (decRegWrite),
      .rfReadAddr1 (rfReadAddr1),
      .rfReadAddr2 (rfReadAddr2),
      .rfReadData1 (rfReadData1),
      .rfReadData2 (rfReadData2),
      .wbEn        (wbEn),
      .wbAddr      (wbAddr),
      .exValid     (exValid),
      .exReady     (exReady),
      .exOpA       (exOpA),
      .exOpB       (exOpB),
      .exRd        (exRd),
      .exRegWrite  (exRegWrite),
      .sbError     (sbError)
   );

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      decValid    = 1'b0;
      decRs       = '0;
      decRt       = '0;
      decRd       = '0;
      decImm      = '0;
      decUseImm   = 1'b0;
      decRegWrite = 1'b0;
      wbEn        = 1'b0;
      wbAddr      = '0;
   endtask

   task automatic offer(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                        input logic [7:0] imm, input logic use_imm, input logic rw);
      decValid    = 1'b1;
      decRs       = rs;
      decRt       = rt;
      decRd       = rd;
      decImm      = imm;
      decUseImm   = use_imm;
      decRegWrite = rw;
      #1;
   endtask

   task automatic test_reset();
      resetN  = 1'b0;
      exReady = 1'b0;
      idle();
      cyc();
      cyc();
      total_cnt++; if (exValid !== 1'b0) $display("FAIL rst_exValid: got %b want 0", exValid); else pass_cnt++;
      total_cnt++; if (exOpA !== 8'h00) $display("FAIL rst_exOpA: got %h want 00", exOpA); else pass_cnt++;
      total_cnt++; if (exOpB !== 8'h00) $display("FAIL rst_exOpB: got %h want 00", exOpB); else pass_cnt++;
      total_cnt++; if (exRd !== 3'd0) $display("FAIL rst_exRd: got %0d want 0", exRd); else pass_cnt++;
      total_cnt++; if (exRegWrite !== 1'b0) $display("FAIL rst_exRegWrite: got %b want 0", exRegWrite); else pass_cnt++;
      total_cnt++; if (sbError !== 1'b0) $display("FAIL rst_sbError: got %b want 0", sbError); else pass_cnt++;
      resetN = 1'b1;
      #1;
      total_cnt++; if (decReady !== 1'b1) $display("FAIL rst_decReady: got %b want 1", decReady); else pass_cnt++;
   endtask

   task automatic test_reset_midstream();
      exReady = 1'b0;
      idle();
      wbEn   = 1'b1;
      wbAddr = 3'd5;
      cyc();
      wbEn = 1'b0;
      total_cnt++; if (sbError !== 1'b1) $display("FAIL mid_sbErrorSet: got %b want 1", sbError); else pass_cnt++;
      offer(3'd1, 3'd2, 3'd4, 8'h00, 1'b0, 1'b1);
      cyc();
      offer(3'd0, 3'd0, 3'd6, 8'h00, 1'b0, 1'b1);
      total_cnt++; if (decReady !== 1'b1) $display("FAIL mid_acceptSecond: got %b want 1", decReady); else pass_cnt++;
      cyc();
      total_cnt++; if (exValid !== 1'b1) $display("FAIL mid_full: got %b want 1", exValid); else pass_cnt++;
      idle();
      decRs  = 3'd4;
      decRt  = 3'd6;
      resetN = 1'b0;
      cyc();
      resetN = 1'b1;
      #1;
      total_cnt++; if (exValid !== 1'b0) $display("FAIL mid_exValid: got %b want 0", exValid); else pass_cnt++;
      total_cnt++; if (decReady !== 1'b1) $display("FAIL mid_decReady: got %b want 1", decReady); else pass_cnt++;
      total_cnt++; if (sbError !== 1'b0) $display("FAIL mid_sbError: got %b want 0", sbError); else pass_cnt++;
      total_cnt++; if (exOpA !== 8'h00) $display("FAIL mid_exOpA: got %h want 00", exOpA); else pass_cnt++;
      idle();
      cyc();
   endtask

   task automatic test_basic_read();
      rf[3]   = 8'h5A;
      exReady = 1'b1;
      offer(3'd3, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0);
      total_cnt++; if (decReady !== 1'b1) $display("FAIL rd_decReady: got %b want 1", decReady); else pass_cnt++;
      cyc();
      idle();
      total_cnt++; if (exValid !== 1'b0) $display("FAIL rd_early: got %b want 0", exValid); else pass_cnt++;
      cyc();
      total_cnt++; if (exValid !== 1'b1) $display("FAIL rd_valid: got %b want 1", exValid); else pass_cnt++;
      total_cnt++; if (exOpA !== 8'h5A) $display("FAIL rd_opA: got %h want 5a", exOpA); else pass_cnt++;
      total_cnt++; if (exOpB !== 8'h5A) $display("FAIL rd_opB: got %h want 5a", exOpB); else pass_cnt++;
      cyc();
      total_cnt++; if (exValid !== 1'b0) $display("FAIL rd_drain: got %b want 0", exValid); else pass_cnt++;
   endtask

   task automatic test_raw_stall();
      rf[2]   = 8'h11;
      exReady = 1'b1;
      offer(3'd0, 3'd0, 3'd2, 8'h00, 1'b1, 1'b1);
      cyc();
      offer(3'd2, 3'd0, 3'd0, 8'h21, 1'b1, 1'b0);
      total_cnt++; if (decReady !== 1'b0) $display("FAIL raw_stall0: got %b want 0", decReady); else pass_cnt++;
      cyc();
      total_cnt++; if (exValid !== 1'b1) $display("FAIL raw_wrValid: got %b want 1", exValid); else pass_cnt++;
      total_cnt++; if (exRd !== 3'd2) $display("FAIL raw_wrRd: got %0d want 2", exRd); else pass_cnt++;
      total_cnt++; if (exRegWrite !== 1'b1) $display("FAIL raw_wrEn: got %b want 1", exRegWrite); else pass_cnt++;
      total_cnt++; if (decReady !== 1'b0) $display("FAIL raw_stall1: got %b want 0", decReady); else pass_cnt++;
      rf[2]  = 8'hC3;
      wbEn   = 1'b1;
      wbAddr = 3'd2;
      #1;
      total_cnt++; if (decReady !== 1'b0) $display("FAIL raw_sameCycleWb: got %b want 0", decReady); else pass_cnt++;
      cyc();
      wbEn = 1'b0;
      #1;
      total_cnt++; if (decReady !== 1'b1) $display("FAIL raw_release: got %b want 1", decReady); else pass_cnt++;
      cyc();
      idle();
      total_cnt++; if (exValid !== 1'b0) $display("FAIL raw_gap: got %b want 0", exValid); else pass_cnt++;
      cyc();
      total_cnt++; if (exValid !== 1'b1) $display("FAIL raw_valid: got %b want 1", exValid); else pass_cnt++;
      total_cnt++; if (exOpA !== 8'hC3) $display("FAIL raw_newData: got %h want c3", exOpA); else pass_cnt++;
      total_cnt++; if (exOpB !== 8'h21) $display("FAIL raw_imm: got %h want 21", exOpB); else pass_cnt++;
      cyc();
   endtask

   task automatic test_backpressure();
      rf[4] = 8'h44;
      rf[5] = 8'h55;
      rf[6] = 8'h66;
      rf[7] = 8'h77;
      exReady = 1'b0;
      offer(3'd4, 3'd5, 3'd1, 8'h00, 1'b0, 1'b0);
      total_cnt++; if (decReady !== 1'b1) $display("FAIL bp_acc0: got %b want 1", decReady); else pass_cnt++;
      cyc();
      offer(3'd6, 3'd7, 3'd2, 8'h00, 1'b0, 1'b0);
      total_cnt++; if (decReady !== 1'b1) $display("FAIL bp_acc1: got %b want 1", decReady); else pass_cnt++;
      cyc();
      total_cnt++; if (exValid !== 1'b1) $display("FAIL bp_valid: got %b want 1", exValid); else pass_cnt++;
      total_cnt++; if (exOpA !== 8'h44) $display("FAIL bp_opA0: got %h want 44", exOpA); else pass_cnt++;
      total_cnt++; if (exOpB !== 8'h55) $display("FAIL bp_opB0: got %h want 55", exOpB); else pass_cnt++;
      offer(3'd5, 3'd0, 3'd3, 8'h99, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if (decReady !== 1'b0) $display("FAIL bp_blocked[%0d]: got %b want 0", i, decReady); else pass_cnt++;
         cyc();
         total_cnt++; if (exValid !== 1'b1) $display("FAIL bp_holdValid[%0d]: got %b want 1", i, exValid); else pass_cnt++;
         total_cnt++; if (exOpA !== 8'h44) $display("FAIL bp_holdA[%0d]: got %h want 44", i, exOpA); else pass_cnt++;
         total_cnt++; if (exOpB !== 8'h55) $display("FAIL bp_holdB[%0d]: got %h want 55", i, exOpB); else pass_cnt++;
         total_cnt++; if (exRd !== 3'd1) $display("FAIL bp_holdRd[%0d]: got %0d want 1", i, exRd); else pass_cnt++;
      end
      exReady = 1'b1;
      #1;
      total_cnt++; if (decReady !== 1'b1) $display("FAIL bp_resume: got %b want 1", decReady); else pass_cnt++;
      cyc();
      idle();
      total_cnt++; if (exOpA !== 8'h66) $display("FAIL bp_opA1: got %h want 66", exOpA); else pass_cnt++;
      total_cnt++; if (exOpB !== 8'h77) $display("FAIL bp_opB1: got %h want 77", exOpB); else pass_cnt++;
      total_cnt++; if (exRd !== 3'd2) $display("FAIL bp_rd1: got %0d want 2", exRd); else pass_cnt++;
      cyc();
      total_cnt++; if (exValid !== 1'b1) $display("FAIL bp_valid2: got %b want 1", exValid); else pass_cnt++;
      total_cnt++; if (exOpA !== 8'h55) $display("FAIL bp_opA2: got %h want 55", exOpA); else pass_cnt++;
      total_cnt++; if (exOpB !== 8'h99) $display("FAIL bp_opB2: got %h want 99", exOpB); else pass_cnt++;
      total_cnt++; if (exRd !== 3'd3) $display("FAIL bp_rd2: got %0d want 3", exRd); else pass_cnt++;
      cyc();
      total_cnt++; if (exValid !== 1'b0) $display("FAIL bp_drain: got %b want 0", exValid); else pass_cnt++;
   endtask

   task automatic test_imm_no_stall();
      rf[1]   = 8'h0F;
      exReady = 1'b1;
      offer(3'd0, 3'd0, 3'd2, 8'h00, 1'b1, 1'b1);
      cyc();
      idle();
      decRs = 3'd1;
      decRt = 3'd2;
      #1;
      total_cnt++; if (decReady !== 1'b0) $display("FAIL imm_rtStall: got %b want 0", decReady); else pass_cnt++;
      offer(3'd1, 3'd2, 3'd0, 8'h7F, 1'b1, 1'b0);
      total_cnt++; if (decReady !== 1'b1) $display("FAIL imm_noStall: got %b want 1", decReady); else pass_cnt++;
      cyc();
      idle();
      cyc();
      total_cnt++; if (exValid !== 1'b1) $display("FAIL imm_valid: got %b want 1", exValid); else pass_cnt++;
      total_cnt++; if (exOpA !== 8'h0F) $display("FAIL imm_opA: got %h want 0f", exOpA); else pass_cnt++;
      total_cnt++; if (exOpB !== 8'h7F) $display("FAIL imm_opB: got %h want 7f", exOpB); else pass_cnt++;
      wbEn   = 1'b1;
      wbAddr = 3'd2;
      cyc();
      wbEn = 1'b0;
      total_cnt++; if (sbError !== 1'b0) $display("FAIL imm_sbError: got %b want 0", sbError); else pass_cnt++;
      cyc();
   endtask

   task automatic test_pend_sat();
      exReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         offer(3'd0, 3'd0, 3'd1, 8'h00, 1'b1, 1'b1);
         total_cnt++; if (decReady !== 1'b1) $display("FAIL sat_acc[%0d]: got %b want 1", i, decReady); else pass_cnt++;
         cyc();
      end
      offer(3'd0, 3'd0, 3'd1, 8'h00, 1'b1, 1'b1);
      total_cnt++; if (decReady !== 1'b0) $display("FAIL sat_full0: got %b want 0", decReady); else pass_cnt++;
      cyc();
      total_cnt++; if (decReady !== 1'b0) $display("FAIL sat_full1: got %b want 0", decReady); else pass_cnt++;
      decValid = 1'b0;
      wbEn     = 1'b1;
      wbAddr   = 3'd1;
      cyc();
      wbEn = 1'b0;
      #1;
      total_cnt++; if (decReady !== 1'b1) $display("FAIL sat_release: got %b want 1", decReady); else pass_cnt++;
      wbEn = 1'b1;
      cyc();
      cyc();
      wbEn = 1'b0;
      total_cnt++; if (sbError !== 1'b0) $display("FAIL sat_noErr: got %b want 0", sbError); else pass_cnt++;
      wbEn = 1'b1;
      cyc();
      wbEn = 1'b0;
      total_cnt++; if (sbError !== 1'b1) $display("FAIL sat_underflow: got %b want 1", sbError); else pass_cnt++;
      offer(3'd1, 3'd0, 3'd1, 8'h00, 1'b1, 1'b1);
      total_cnt++; if (decReady !== 1'b1) $display("FAIL sat_cntZero: got %b want 1", decReady); else pass_cnt++;
      cyc();
      idle();
      decRs = 3'd1;
      #1;
      total_cnt++; if (decReady !== 1'b0) $display("FAIL sat_pendAgain: got %b want 0", decReady); else pass_cnt++;
      total_cnt++; if (sbError !== 1'b1) $display("FAIL sat_sticky: got %b want 1", sbError); else pass_cnt++;
      idle();
      cyc();
      cyc();
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         rf[i] = 8'h00;
      end
      test_reset();
      test_reset_midstream();
      test_basic_read();
      test_raw_stall();
      test_backpressure();
      test_imm_no_stall();
      test_pend_sat();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
